// File: rtl/adc_sar_pkg.sv
// Shared types for the SAR scan sequencer: state encoding, timeout default
// and the tagged result word.
package adc_sar_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SELECT   = 3'd1,
      S_SETTLE   = 3'd2,
      S_SOC      = 3'd3,
      S_WAIT_EOC = 3'd4,
      S_STORE    = 3'd5
   } seq_state_t;

   localparam int TMO_CYC_DEF = 64;
   localparam int RES_N       = 8;
   localparam int RES_CH_W    = 2;

   // Result storage is built on this tag, so N/CH_W of the sequencer track these.
   typedef struct packed {
      logic [RES_CH_W-1:0] ch;
      logic [RES_N-1:0]    data;
   } res_tag_t;

endpackage

// File: rtl/adc_sar_sequencer_if.sv
// ADC core handshake plus result bus; master = sequencer, slave = core/consumer.
interface adc_sar_sequencer_if #(
   parameter int N    = 8,
   parameter int CH_W = 2
);
   logic            adc_soc;
   logic [CH_W-1:0] adc_ch_sel;
   logic            adc_rdy;
   logic            adc_eoc;
   logic [N-1:0]    adc_data;
   logic            result_valid;
   logic [CH_W-1:0] result_ch;
   logic [N-1:0]    result_data;
   logic            result_ack;

   modport master (
      output adc_soc, adc_ch_sel, result_valid, result_ch, result_data,
      input  adc_rdy, adc_eoc, adc_data, result_ack
   );

   modport slave (
      input  adc_soc, adc_ch_sel, result_valid, result_ch, result_data,
      output adc_rdy, adc_eoc, adc_data, result_ack
   );
endinterface

// File: rtl/adc_sar_ch_pick.sv
// Priority finder: lowest set mask bit at an index >= ptr_i, with found flag.
module adc_sar_ch_pick #(
   parameter int NCH  = 4,
   parameter int CH_W = 2
) (
   input  logic [NCH-1:0]  mask_i,
   input  logic [CH_W:0]   ptr_i,
   output logic [CH_W-1:0] idx_o,
   output logic            found_o
);

   // Descending walk so the lowest qualifying index is the last one written.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask_i[i] && (i >= int'(ptr_i))) begin
            idx_o   = CH_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_sar_sequencer.sv
// Masked channel scan controller in front of the SAR core: mux select, settle,
// SOC/EOC handshake, tagged result capture with overrun and timeout flags.
module adc_sar_sequencer
   import adc_sar_pkg::*;
#(
   parameter int N        = RES_N,
   parameter int NCH      = 4,
   parameter int CH_W     = RES_CH_W,
   parameter int SETTLE_W = 4,
   parameter int TMO_CYC  = TMO_CYC_DEF
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                enable,
   input  logic                start,
   input  logic                cont,
   input  logic [NCH-1:0]      ch_mask,
   input  logic [SETTLE_W-1:0] settle_cyc,
   adc_sar_sequencer_if.master bus,
   output logic                busy,
   output logic                overrun,
   output logic                timeout
);

   localparam int TMO_W = $clog2(TMO_CYC + 1);

   seq_state_t          state_q, state_d;
   logic [NCH-1:0]      mask_q, mask_d;
   logic [CH_W:0]       ptr_q, ptr_d;
   logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                soc_q, soc_d;
   res_tag_t            res_q, res_d;
   logic                res_valid_q, res_valid_d;
   logic                overrun_q, overrun_d;
   logic                timeout_q, timeout_d;

   logic [CH_W:0]       pick_ptr;
   logic [CH_W-1:0]     pick_idx;
   logic                pick_found;
   logic [N-1:0]        data_in;
   logic                accept;
   logic                tmo_hit;

   assign data_in = bus.adc_data;
   assign accept  = start && (|ch_mask);
   assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC - 1));

   // In STORE the finder looks past the channel just converted (end-of-scan test).
   assign pick_ptr = (state_q == S_STORE) ? ({1'b0, ch_sel_q} + 1'b1) : ptr_q;

   adc_sar_ch_pick #(.NCH(NCH), .CH_W(CH_W)) u_pick (
      .mask_i  (mask_q),
      .ptr_i   (pick_ptr),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         ptr_q       <= '0;
         ch_sel_q    <= '0;
         settle_q    <= '0;
         tmo_q       <= '0;
         soc_q       <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         ptr_q       <= ptr_d;
         ch_sel_q    <= ch_sel_d;
         settle_q    <= settle_d;
         tmo_q       <= tmo_d;
         soc_q       <= soc_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:     if (accept) state_d = S_SELECT;
            S_SELECT:   state_d = pick_found ? S_SETTLE : S_IDLE;
            S_SETTLE:   if (settle_q == '0) state_d = S_SOC;
            S_SOC:      if (bus.adc_rdy) state_d = S_WAIT_EOC;
            S_WAIT_EOC: begin
               if (bus.adc_eoc)  state_d = S_STORE;
               else if (tmo_hit) state_d = S_IDLE;
            end
            S_STORE: begin
               if (pick_found)              state_d = S_SELECT;
               else if (cont && |ch_mask)   state_d = S_SELECT;
               else                         state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
         endcase
      end
   end

   // The result word is written on the EOC edge so valid follows EOC by one
   // cycle; the STORE cycle then only advances the scan pointer.
   always_comb begin
      mask_d      = mask_q;
      ptr_d       = ptr_q;
      ch_sel_d    = ch_sel_q;
      settle_d    = settle_q;
      tmo_d       = tmo_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      overrun_d   = overrun_q;
      timeout_d   = timeout_q;
      soc_d       = (state_d == S_SOC);
      busy        = (state_q != S_IDLE);

      if (bus.result_ack) res_valid_d = 1'b0;

      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  mask_d    = ch_mask;
                  ptr_d     = '0;
                  overrun_d = 1'b0;
                  timeout_d = 1'b0;
               end
            end
            S_SELECT: begin
               ch_sel_d = pick_idx;
               settle_d = settle_cyc;
            end
            S_SETTLE: if (settle_q != '0) settle_d = settle_q - 1'b1;
            S_SOC:    tmo_d = '0;
            S_WAIT_EOC: begin
               if (bus.adc_eoc) begin
                  res_d.ch    = ch_sel_q;
                  res_d.data  = data_in;
                  res_valid_d = 1'b1;
                  if (res_valid_q && !bus.result_ack) overrun_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + 1'b1;
                  if (tmo_hit) timeout_d = 1'b1;
               end
            end
            S_STORE: begin
               ptr_d = pick_ptr;
               if (!pick_found && cont) begin
                  mask_d = ch_mask;
                  ptr_d  = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.adc_soc      = soc_q;
   assign bus.adc_ch_sel   = ch_sel_q;
   assign bus.result_valid = res_valid_q;
   assign bus.result_ch    = res_q.ch;
   assign bus.result_data  = res_q.data;
   assign overrun          = overrun_q;
   assign timeout          = timeout_q;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Scoreboard bench: a core model answers SOC/EOC, expected channel order comes
// from the mask, and a monitor consumes and checks each presented result.
module tb_adc_sar_sequencer;
   import adc_sar_pkg::*;

   localparam int N = 8, NCH = 4, CH_W = 2, SETTLE_W = 4, TMO = 64;

   logic                clk = 1'b0;
   logic                rstb, enable, start, cont;
   logic [NCH-1:0]      ch_mask;
   logic [SETTLE_W-1:0] settle_cyc;
   logic                busy, overrun, timeout;

   adc_sar_sequencer_if #(.N(N), .CH_W(CH_W)) bus ();

   adc_sar_sequencer #(.N(N), .NCH(NCH), .CH_W(CH_W), .SETTLE_W(SETTLE_W), .TMO_CYC(TMO)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .enable     (enable),
      .start      (start),
      .cont       (cont),
      .ch_mask    (ch_mask),
      .settle_cyc (settle_cyc),
      .bus        (bus),
      .busy       (busy),
      .overrun    (overrun),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   int exp_sel_q[$];
   int exp_res_q[$];
   logic [7:0] core_data_q[$];
   logic [7:0] last_data = 8'h00;
   int core_stall = 0, core_dly = 3, ack_mode = 1;
   bit core_no_eoc = 1'b0;
   int soc_hi = 0, eoc_ct = 0, hs_cnt = 0, hs_cyc = 0;
   bit eoc_pend = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Core model: holds rdy low for core_stall SOC cycles, pulses EOC core_dly cycles later.
   always @(negedge clk) begin
      if (!rstb) begin
         bus.adc_rdy  = 1'b0;
         bus.adc_eoc  = 1'b0;
         bus.adc_data = '0;
         soc_hi       = 0;
         eoc_pend     = 1'b0;
      end else begin
         bus.adc_eoc = 1'b0;
         if (bus.adc_rdy) begin
            bus.adc_rdy = 1'b0;
            hs_cnt++;
            hs_cyc = cyc;
            chk("soc_len", soc_hi, core_stall + 1);
            soc_hi = 0;
            if (!core_no_eoc) begin
               eoc_pend = 1'b1;
               eoc_ct   = core_dly;
            end
         end else if (bus.adc_soc) begin
            soc_hi++;
            if (soc_hi == 1) begin
               if (exp_sel_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL ch_sel: got SOC on ch %0d, want no SOC", bus.adc_ch_sel);
               end else begin
                  chk("ch_sel", bus.adc_ch_sel, exp_sel_q.pop_front());
               end
            end
            if (soc_hi > core_stall) bus.adc_rdy = 1'b1;
         end
         if (eoc_pend) begin
            eoc_ct--;
            if (eoc_ct == 0) begin
               eoc_pend     = 1'b0;
               last_data    = 8'($urandom);
               bus.adc_data = last_data;
               bus.adc_eoc  = 1'b1;
               core_data_q.push_back(last_data);
            end
         end
      end
   end

   // Monitor: ack_mode 0 = hold results, 1 = check and ack, 2 = ack without checking.
   always @(negedge clk) begin
      if (!rstb) begin
         bus.result_ack = 1'b0;
      end else begin
         bus.result_ack = 1'b0;
         if (bus.result_valid === 1'b1 && ack_mode != 0) begin
            bus.result_ack = 1'b1;
            if (ack_mode == 1) begin
               if (exp_res_q.size() == 0 || core_data_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL result: got ch %0d data %0d, want no result", bus.result_ch, bus.result_data);
               end else begin
                  chk("res_ch", bus.result_ch, exp_res_q.pop_front());
                  chk("res_data", bus.result_data, core_data_q.pop_front());
               end
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle(input string name, input int bound);
      int k = 0;
      while (busy !== 1'b0 && k < bound) begin
         step();
         k++;
      end
      if (busy !== 1'b0) begin
         tests++; fails++;
         $display("FAIL %s: got busy after %0d cycles, want idle", name, bound);
      end
   endtask

   // Reference scan order: every set mask bit, ascending.
   task automatic push_scan(input logic [3:0] m, input bit res);
      for (int i = 0; i < NCH; i++) begin
         if (m[i]) begin
            exp_sel_q.push_back(i);
            if (res) exp_res_q.push_back(i);
         end
      end
   endtask

   task automatic kick(input logic [3:0] m);
      ch_mask = m;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] m;
      logic [7:0] saved;
      int base, k;
      rstb = 1'b0; enable = 1'b0; start = 1'b0; cont = 1'b0;
      ch_mask = '0; settle_cyc = '0;
      step(3);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_soc", bus.adc_soc, 0);
      chk("rst_ch_sel", bus.adc_ch_sel, 0);
      chk("rst_valid", bus.result_valid, 0);
      chk("rst_res_ch", bus.result_ch, 0);
      chk("rst_res_data", bus.result_data, 0);
      rstb = 1'b1; enable = 1'b1;
      step(2);

      for (int s = 0; s < 8; s++) begin
         m          = 4'($urandom_range(1, 15));
         settle_cyc = 4'($urandom_range(0, 5));
         core_stall = $urandom_range(0, 3);
         core_dly   = $urandom_range(1, 12);
         if (s == 0) begin
            m = 4'b1011; settle_cyc = 4'd2; core_stall = 0; core_dly = 10;
         end
         if (s == 1) core_stall = 5;
         push_scan(m, 1'b1);
         kick(m);
         wait_idle("scan_idle", 2000);
         step(3);
         chk("scan_drain", exp_res_q.size(), 0);
         chk("scan_overrun", overrun, 0);
         chk("scan_timeout", timeout, 0);
      end

      // Continuous scan on ch 2; drop cont while the 6th conversion is in flight.
      base = hs_cnt; cont = 1'b1; settle_cyc = '0; core_stall = 0; core_dly = 4;
      for (int i = 0; i < 6; i++) begin
         exp_sel_q.push_back(2);
         exp_res_q.push_back(2);
      end
      kick(4'b0100);
      k = 0;
      while (hs_cnt < base + 6 && k < 500) begin
         step();
         k++;
      end
      cont = 1'b0;
      wait_idle("cont_idle", 500);
      step(3);
      chk("cont_conv", hs_cnt - base, 6);
      chk("cont_drain", exp_res_q.size(), 0);

      // No acks over a 2-channel scan.
      ack_mode = 0; core_dly = 3; settle_cyc = 4'd1;
      push_scan(4'b0110, 1'b0);
      kick(4'b0110);
      wait_idle("ovr_idle", 500);
      step(2);
      chk("ovr_flag", overrun, 1);
      chk("ovr_valid", bus.result_valid, 1);
      chk("ovr_ch", bus.result_ch, 2);
      chk("ovr_data", bus.result_data, last_data);

      // Core never answers: timeout exactly TMO cycles after the handshake.
      saved = last_data; core_no_eoc = 1'b1;
      push_scan(4'b0001, 1'b0);
      kick(4'b0001);
      chk("start_clr_ovr", overrun, 0);
      k = 0;
      while (timeout !== 1'b1 && k < 300) begin
         step();
         k++;
      end
      chk("tmo_latency", cyc - hs_cyc, TMO);
      chk("tmo_busy", busy, 0);
      chk("tmo_valid", bus.result_valid, 1);
      chk("tmo_res_ch", bus.result_ch, 2);
      chk("tmo_res_data", bus.result_data, saved);

      core_no_eoc = 1'b0; core_dly = 2; ack_mode = 2;
      push_scan(4'b0001, 1'b0);
      kick(4'b0001);
      chk("start_clr_tmo", timeout, 0);
      wait_idle("clr_idle", 500);
      step(3);
      chk("flush_valid", bus.result_valid, 0);
      core_data_q.delete();
      ack_mode = 1;

      // enable low during SETTLE.
      settle_cyc = 4'd10;
      kick(4'b0001);
      step(3);
      chk("abort_busy_pre", busy, 1);
      enable = 1'b0;
      step();
      chk("abort_busy", busy, 0);
      chk("abort_soc", bus.adc_soc, 0);
      enable = 1'b1;
      step(12);
      chk("abort_stay_idle", busy, 0);

      ch_mask = '0; start = 1'b1;
      step();
      start = 1'b0;
      chk("mask0_busy", busy, 0);
      step(2);
      chk("mask0_busy_late", busy, 0);

      // Reset while waiting for EOC with a held result on ch 2.
      ack_mode = 0; settle_cyc = '0; core_dly = 2;
      push_scan(4'b0100, 1'b0);
      kick(4'b0100);
      wait_idle("pre_rst_idle", 500);
      step(2);
      chk("pre_rst_valid", bus.result_valid, 1);
      core_no_eoc = 1'b1; base = hs_cnt;
      push_scan(4'b0100, 1'b0);
      kick(4'b0100);
      k = 0;
      while (hs_cnt == base && k < 100) begin
         step();
         k++;
      end
      step(2);
      chk("pre_rst_busy", busy, 1);
      rstb = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_soc", bus.adc_soc, 0);
      chk("arst_ch_sel", bus.adc_ch_sel, 0);
      chk("arst_valid", bus.result_valid, 0);
      chk("arst_res_ch", bus.result_ch, 0);
      chk("arst_res_data", bus.result_data, 0);
      chk("arst_overrun", overrun, 0);
      chk("arst_timeout", timeout, 0);
      step(2);
      rstb = 1'b1;
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
